regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file between two writers: the five-stage pipeline's writeback stage (WB) and the multicycle multiply/divide unit (MD). WB has priority; MD results queue in a small FIFO and drain into idle write slots. A starvation guard forces a one-cycle WB hold so MD results always land. An optional scoreboard tracks registers with MD results still outstanding, for the hazard unit.

---
 rtl/rf_arb_pkg.sv | 12 +
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/rf_arb_fifo.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, grant/starve enums and the MD FIFO entry type
package rf_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_FIFO} gnt_e;
    typedef enum logic {ST_NORMAL, ST_HOLD} starve_e;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } md_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: WB/MD request side and register-file write side of the arbiter
//   master: the pipeline/MD unit (drives requests, sees hold/ready/busy/write)
//   slave:  the arbiter
interface regfile_write_arbiter_if;
    import rf_arb_pkg::*;
    logic wbValid;
    logic [REG_ADDR_W-1:0] wbReg;
    logic [DATA_W-1:0] wbData;
    logic wbHold;
    logic mdValid;
    logic mdReady;
    logic [REG_ADDR_W-1:0] mdReg;
    logic [DATA_W-1:0] mdData;
    logic mdIssue;
    logic [REG_ADDR_W-1:0] mdIssueReg;
    logic [NUM_REGS-1:0] busyMask;
    logic RegWrite;
    logic [REG_ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    modport master(
        output wbValid, wbReg, wbData, mdValid, mdReg, mdData, mdIssue, mdIssueReg,
        input wbHold, mdReady, busyMask, RegWrite, writeReg, writeData
    );
    modport slave(
        input wbValid, wbReg, wbData, mdValid, mdReg, mdData, mdIssue, mdIssueReg,
        output wbHold, mdReady, busyMask, RegWrite, writeReg, writeData
    );
endinterface

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: synchronous FIFO holding MD results until they win a write slot
//   clk, rst_n   clock, async active-low reset (empties the queue)
//   push, din    enqueue din (caller guarantees !full)
//   pop, head    dequeue; head is the oldest entry, valid while !empty
//   full, empty  occupancy flags
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  md_entry_t din,
    output md_entry_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    md_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between WB (priority) and queued MD results
//   CLK, RST_N   clock, async active-low reset
//   bus (slave)  WB request/hold, MD result/ready, MD issue, busyMask, registered write port
// Optional build macro RF_ARB_SCOREBOARD_EN adds the busyMask scoreboard; without it busyMask is 0.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic CLK,
    input logic RST_N,
    regfile_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LAST_LOSS = CW'(STARVE_LIMIT - 1);
    gnt_e gnt;
    starve_e state;
    logic [CW-1:0] starve_cnt;
    logic fifo_full, fifo_empty, push, pop, starving;
    md_entry_t md_in, head;
    logic [REG_ADDR_W-1:0] sel_reg, write_reg;
    logic [DATA_W-1:0] sel_data, write_data;
    logic reg_write;
    assign md_in = '{addr: bus.mdReg, data: bus.mdData};
    assign bus.mdReady = !fifo_full;
    assign push = bus.mdValid && !fifo_full;
    assign bus.wbHold = state == ST_HOLD;
    // A hold cycle always has a non-empty FIFO: it is only entered after losing to WB with entries waiting.
    always_comb begin
        gnt = bus.wbHold ? GNT_FIFO : bus.wbValid ? GNT_WB : !fifo_empty ? GNT_FIFO : GNT_NONE;
    end
    assign pop = gnt == GNT_FIFO;
    assign sel_reg = pop ? head.addr : bus.wbReg;
    assign sel_data = pop ? head.data : bus.wbData;
    assign starving = !fifo_empty && gnt == GNT_WB;
    rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK),
        .rst_n(RST_N),
        .push(push),
        .pop(pop),
        .din(md_in),
        .head(head),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_NORMAL;
            starve_cnt <= '0;
        end else if (state == ST_HOLD) begin
            state <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starving ? starve_cnt + 1'b1 : '0;
            state <= starving && starve_cnt == LAST_LOSS ? ST_HOLD : ST_NORMAL;
        end
    end
    // Register-0 grants still consume the request (and pop the FIFO) but never enable the write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_write <= 1'b0;
            write_reg <= '0;
            write_data <= '0;
        end else begin
            reg_write <= gnt != GNT_NONE && sel_reg != '0;
            if (gnt != GNT_NONE) begin
                write_reg <= sel_reg;
                write_data <= sel_data;
            end
        end
    end
    assign bus.RegWrite = reg_write;
    assign bus.writeReg = write_reg;
    assign bus.writeData = write_data;
`ifdef RF_ARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy, set_mask, clr_mask;
    // Clearing at grant time lands the bit drop on the same edge that raises RegWrite; a same-cycle issue wins.
    assign set_mask = bus.mdIssue ? (NUM_REGS'(1) << bus.mdIssueReg) & ~NUM_REGS'(1) : '0;
    assign clr_mask = pop ? NUM_REGS'(1) << head.addr : '0;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) busy <= '0;
        else busy <= (busy & ~clr_mask) | set_mask;
    end
    assign bus.busyMask = busy;
`else
    logic unused_issue;
    assign unused_issue = ^{bus.mdIssue, bus.mdIssueReg};
    assign bus.busyMask = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: randomized + directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    import rf_arb_pkg::*;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    typedef struct {
        logic [4:0] r;
        logic [31:0] d;
    } ent_t;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    regfile_write_arbiter_if bus();
    regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );
    always #5 CLK = ~CLK;
    int checks = 0;
    int errors = 0;
    ent_t exp_q[$];
    ent_t mq[$];
    ent_t md_src[$];
    bit m_hold, held_last;
    int cnt;
    logic [31:0] m_busy;
    logic cur_wv;
    logic [4:0] cur_wr;
    logic [31:0] cur_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mq.delete();
        md_src.delete();
        m_hold = 0;
        held_last = 0;
        cnt = 0;
        m_busy = '0;
        cur_wv = 0;
        cur_wr = '0;
        cur_wd = '0;
        bus.wbValid = 0;
        bus.wbReg = '0;
        bus.wbData = '0;
        bus.mdValid = 0;
        bus.mdReg = '0;
        bus.mdData = '0;
        bus.mdIssue = 0;
        bus.mdIssueReg = '0;
    endtask

    // One clock: check state after the last edge, drive this cycle, advance the reference model.
    task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ir);
        ent_t e;
        bit had, acc, g_fifo, g_wb;
        @(posedge CLK);
        #1;
        chk("wbHold", bus.wbHold, m_hold);
        chk("mdReady", bus.mdReady, mq.size() < DEPTH);
        chk("busyMask", bus.busyMask, m_busy);
        if (!held_last) begin
            cur_wv = wv;
            cur_wr = wr;
            cur_wd = wd;
        end
        bus.wbValid = cur_wv;
        bus.wbReg = cur_wr;
        bus.wbData = cur_wd;
        bus.mdValid = md_src.size() > 0;
        bus.mdReg = md_src.size() > 0 ? md_src[0].r : 5'd0;
        bus.mdData = md_src.size() > 0 ? md_src[0].d : 32'd0;
        bus.mdIssue = iv;
        bus.mdIssueReg = ir;
        had = mq.size() > 0;
        acc = md_src.size() > 0 && mq.size() < DEPTH;
        g_fifo = m_hold || (!cur_wv && had);
        g_wb = !m_hold && cur_wv;
        if (g_fifo) begin
            e = mq.pop_front();
            if (e.r != 0) exp_q.push_back(e);
`ifdef RF_ARB_SCOREBOARD_EN
            m_busy[e.r] = 1'b0;
`endif
        end else if (g_wb && cur_wr != 0) begin
            exp_q.push_back('{r: cur_wr, d: cur_wd});
        end
`ifdef RF_ARB_SCOREBOARD_EN
        if (iv && ir != 0) m_busy[ir] = 1'b1;
`endif
        if (acc) mq.push_back(md_src.pop_front());
        held_last = m_hold;
        if (m_hold) begin
            m_hold = 0;
            cnt = 0;
        end else if (had && g_wb) begin
            cnt++;
            if (cnt == LIMIT) m_hold = 1;
        end else begin
            cnt = 0;
        end
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0);
    endtask

    task automatic busy_wb();
        step(1, 5'($urandom_range(1, 31)), $urandom, 0, 5'd0);
    endtask

    // Monitor: every registered write must match the oldest expected grant.
    always @(negedge CLK) begin
        if (RST_N && bus.RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h, expected no write at %0t",
                         bus.writeReg, bus.writeData, $time);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                if (bus.writeReg !== e.r || bus.writeData !== e.d) begin
                    errors++;
                    $display("FAIL write: got reg %0d data 0x%08h expected reg %0d data 0x%08h at %0t",
                             bus.writeReg, bus.writeData, e.r, e.d, $time);
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        #12;
        chk("rst_RegWrite", bus.RegWrite, 0);
        chk("rst_writeReg", bus.writeReg, 0);
        chk("rst_writeData", bus.writeData, 0);
        chk("rst_wbHold", bus.wbHold, 0);
        chk("rst_busyMask", bus.busyMask, 0);
        chk("rst_mdReady", bus.mdReady, 1);
        @(negedge CLK);
        RST_N = 1;
        // lone WB write
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0);
        repeat (2) idle();
        // MD drain with prior issue
        step(0, 5'd0, 32'd0, 1, 5'd9);
        md_src.push_back('{r: 5'd9, d: 32'h1234});
        repeat (4) idle();
        // contention: one queued MD result against continuous WB
        md_src.push_back('{r: 5'd3, d: 32'h00C0FFEE});
        repeat (10) busy_wb();
        repeat (3) idle();
        // back-pressure: three MD results while WB is busy
        md_src.push_back('{r: 5'd20, d: 32'hA0});
        md_src.push_back('{r: 5'd21, d: 32'hA1});
        md_src.push_back('{r: 5'd22, d: 32'hA2});
        repeat (14) busy_wb();
        repeat (4) idle();
        // register 0 write, then issue/write race on reg 7
        step(1, 5'd0, 32'h00000BAD, 0, 5'd0);
        md_src.push_back('{r: 5'd7, d: 32'h77});
        step(0, 5'd0, 32'd0, 1, 5'd7);
        step(0, 5'd0, 32'd0, 1, 5'd7);
        repeat (3) idle();
        // reset mid-drain: two entries queued and a hold pending
        md_src.push_back('{r: 5'd11, d: 32'hAAAA0001});
        md_src.push_back('{r: 5'd12, d: 32'hAAAA0002});
        n = 0;
        do begin
            busy_wb();
            n++;
        end while (!(m_hold && mq.size() == 2) && n < 20);
        chk("reach_hold_state", {31'd0, m_hold}, 1);
        @(posedge CLK);
        #2;
        chk("hold_before_reset", bus.wbHold, 1);
        RST_N = 0;
        #1;
        chk("mid_rst_RegWrite", bus.RegWrite, 0);
        chk("mid_rst_writeReg", bus.writeReg, 0);
        chk("mid_rst_writeData", bus.writeData, 0);
        chk("mid_rst_wbHold", bus.wbHold, 0);
        chk("mid_rst_busyMask", bus.busyMask, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1;
        #1;
        chk("mdReady_after_reset", bus.mdReady, 1);
        repeat (3) idle();
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (md_src.size() < 3 && $urandom_range(0, 9) < 3)
                md_src.push_back('{r: 5'($urandom_range(0, 31)), d: $urandom});
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 9) < 2, 5'($urandom_range(0, 31)));
        end
        n = 0;
        while ((exp_q.size() != 0 || mq.size() != 0 || md_src.size() != 0) && n < 30) begin
            idle();
            n++;
        end
        idle();
        chk("drain_complete", exp_q.size(), 0);
        chk("fifo_model_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
